// File: rtl/regfile_write_buffer.sv
// rtl/regfile_write_buffer.sv - register write queue ahead of RegisterFile with read forwarding (option: WB_COALESCE_EN)
module regfile_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          WbValid,
    output logic          WbReady,
    input  logic [AW-1:0] WbRegister,
    input  logic [DW-1:0] WbData,
    input  logic          DrainEn,
    output logic [AW-1:0] WriteRegister,
    output logic [DW-1:0] WriteData,
    output logic          RegWrite,
    input  logic [AW-1:0] ReadRegister1,
    input  logic [AW-1:0] ReadRegister2,
    input  logic [DW-1:0] RfReadData1,
    input  logic [DW-1:0] RfReadData2,
    output logic [DW-1:0] ReadData1,
    output logic [DW-1:0] ReadData2,
    output logic          Empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW:0]   CNT_DEPTH = (PW+1)'(DEPTH);

    logic [AW-1:0] reg_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [PW:0]   count;

    logic          not_empty;
    logic          full;
    logic          pop;
    logic          accept;
    logic          push;
    logic          coalesce;
    logic [PW-1:0] youngest_ptr;
    logic [PW-1:0] fwd_idx;

    assign not_empty    = (count != '0);
    assign full         = (count == CNT_DEPTH);
    assign pop          = DrainEn & not_empty;
    assign youngest_ptr = tail_ptr - PTR_ONE;

`ifdef WB_COALESCE_EN
    logic youngest_hit;
    // A full queue can still take a write that lands on its youngest entry;
    // with DEPTH >= 2 that entry is never the head, so readiness stays
    // independent of this cycle's drain.
    assign youngest_hit = not_empty && (reg_q[youngest_ptr] == WbRegister);
    assign WbReady      = !full || youngest_hit;
    // A lone head entry that is popping this edge cannot absorb the new data.
    assign coalesce     = youngest_hit && (WbRegister != '0) && !((count == CNT_ONE) && pop);
`else
    assign WbReady      = !full;
    assign coalesce     = 1'b0;
`endif

    assign accept = WbValid & WbReady;
    // Writes to $0 complete the handshake but are never stored.
    assign push   = accept & (WbRegister != '0) & !coalesce;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                reg_q[tail_ptr]  <= WbRegister;
                data_q[tail_ptr] <= WbData;
                tail_ptr         <= tail_ptr + PTR_ONE;
            end
            if (accept && coalesce) begin
                data_q[youngest_ptr] <= WbData;
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign RegWrite      = pop;
    assign WriteRegister = not_empty ? reg_q[head_ptr]  : '0;
    assign WriteData     = not_empty ? data_q[head_ptr] : '0;
    assign Empty         = !not_empty;

    // Walk oldest to youngest so the last match wins; the head entry is
    // included because the register file only sees it after this edge.
    always_comb begin
        ReadData1 = RfReadData1;
        ReadData2 = RfReadData2;
        fwd_idx   = head_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_ptr + PW'(k);
            if ((PW+1)'(k) < count) begin
                if (reg_q[fwd_idx] == ReadRegister1) begin
                    ReadData1 = data_q[fwd_idx];
                end
                if (reg_q[fwd_idx] == ReadRegister2) begin
                    ReadData2 = data_q[fwd_idx];
                end
            end
        end
        if (ReadRegister1 == '0) begin
            ReadData1 = '0;
        end
        if (ReadRegister2 == '0) begin
            ReadData2 = '0;
        end
    end

endmodule
